// File: rtl/rst_seq.sv
// Reset sequencer after the 25 MHz PLL: waits for a stable lock, releases staged
// resets in order, then provides ready and a periodic tick until lock is lost.
module rst_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 16,
  parameter int TICK_DIV      = 25000
) (
  input  logic                  clock_in,
  input  logic                  rst_in,
  input  logic                  locked_in,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  tick,
  output logic [7:0]            lock_loss_cnt,
  output logic [1:0]            state_dbg
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [SW-1:0]         r_stableCnt, w_stableCnt;
  logic [GW-1:0]         r_gapCnt, w_gapCnt;
  logic [TW-1:0]         r_tickCnt, w_tickCnt;
  logic [NUM_STAGES-1:0] r_rstOut, w_rstOut;
  logic                  r_ready, w_ready;
  logic                  r_tick, w_tick;
  logic [7:0]            r_lossCnt, w_lossCnt;
  logic [NUM_STAGES-1:0] w_rstShift;
  logic                  w_lockLoss;

  // Stages release low bit first, so each release is a left shift with zero fill.
  assign w_rstShift = r_rstOut << 1;
  assign w_lockLoss = !locked_in && (r_state != HOLD);

  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_stableCnt = r_stableCnt;
    w_gapCnt    = r_gapCnt;
    w_tickCnt   = r_tickCnt;
    w_rstOut    = r_rstOut;
    w_ready     = r_ready;
    w_tick      = 1'b0;
    w_lossCnt   = r_lossCnt;

    case (r_state)
      HOLD: begin
        if (!locked_in) begin
          w_stableCnt = '0;
        end else if (r_stableCnt == STABLE_LAST) begin
          w_stableCnt = '0;
          w_gapCnt    = '0;
          w_rstOut    = w_rstShift;
          if (w_rstShift == '0) begin
            w_nextState = RUN;
            w_ready     = 1'b1;
          end else begin
            w_nextState = RELEASE;
          end
        end else begin
          w_stableCnt = r_stableCnt + SW'(1);
        end
      end
      RELEASE: begin
        if (r_gapCnt == GAP_LAST) begin
          w_gapCnt = '0;
          w_rstOut = w_rstShift;
          if (w_rstShift == '0) begin
            w_nextState = RUN;
            w_ready     = 1'b1;
          end
        end else begin
          w_gapCnt = r_gapCnt + GW'(1);
        end
      end
      RUN: begin
        if (r_tickCnt == TICK_LAST) begin
          w_tickCnt = '0;
          w_tick    = 1'b1;
        end else begin
          w_tickCnt = r_tickCnt + TW'(1);
        end
      end
      default: begin
        w_nextState = HOLD;
      end
    endcase

    // A lock drop outranks any stage release or tick that would happen on this edge.
    if (w_lockLoss) begin
      w_nextState = HOLD;
      w_stableCnt = '0;
      w_gapCnt    = '0;
      w_tickCnt   = '0;
      w_rstOut    = '1;
      w_ready     = 1'b0;
      w_tick      = 1'b0;
      if (r_lossCnt != 8'hFF) begin
        w_lossCnt = r_lossCnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      r_stableCnt <= '0;
      r_gapCnt    <= '0;
      r_tickCnt   <= '0;
      r_rstOut    <= '1;
      r_ready     <= 1'b0;
      r_tick      <= 1'b0;
      r_lossCnt   <= 8'd0;
    end else begin
      r_stableCnt <= w_stableCnt;
      r_gapCnt    <= w_gapCnt;
      r_tickCnt   <= w_tickCnt;
      r_rstOut    <= w_rstOut;
      r_ready     <= w_ready;
      r_tick      <= w_tick;
      r_lossCnt   <= w_lossCnt;
    end
  end

  assign rst_out       = r_rstOut;
  assign ready         = r_ready;
  assign tick          = r_tick;
  assign lock_loss_cnt = r_lossCnt;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a per-edge lock model predicts every output,
// and a monitor compares the DUT against those predictions one edge later.
module tb_rst_seq;

  localparam int STABLE_CYCLES = 8;
  localparam int NUM_STAGES    = 3;
  localparam int STAGE_GAP     = 4;
  localparam int TICK_DIV      = 5;
  localparam int RUN_OFFSET    = (NUM_STAGES - 1) * STAGE_GAP;

  typedef struct packed {
    logic [NUM_STAGES-1:0] rstOut;
    logic                  ready;
    logic                  tick;
    logic [7:0]            lossCnt;
    logic [1:0]            state;
  } exp_t;

  logic                  clock_in;
  logic                  rst_in;
  logic                  locked_in;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic                  tick;
  logic [7:0]            lock_loss_cnt;
  logic [1:0]            state_dbg;

  exp_t  expQ[$];
  int    assertCount;
  int    failCount;
  string scenario;

  // Model: count consecutive highs, then count edges since release started.
  int    mHighRun;
  bit    mStarted;
  int    mK;
  int    mLoss;

  rst_seq #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .NUM_STAGES   (NUM_STAGES),
    .STAGE_GAP    (STAGE_GAP),
    .TICK_DIV     (TICK_DIV)
  ) dut (
    .clock_in     (clock_in),
    .rst_in       (rst_in),
    .locked_in    (locked_in),
    .rst_out      (rst_out),
    .ready        (ready),
    .tick         (tick),
    .lock_loss_cnt(lock_loss_cnt),
    .state_dbg    (state_dbg)
  );

  initial clock_in = 1'b0;
  always #20 clock_in = ~clock_in;

  task automatic modelReset();
    mHighRun = 0;
    mStarted = 0;
    mK       = 0;
    mLoss    = 0;
  endtask

  task automatic modelStep(input logic lk);
    if (!lk) begin
      if (mStarted) mLoss = (mLoss == 255) ? 255 : mLoss + 1;
      mStarted = 0;
      mHighRun = 0;
      mK       = 0;
    end else if (mStarted) begin
      mK++;
    end else begin
      mHighRun++;
      if (mHighRun == STABLE_CYCLES) begin
        mStarted = 1;
        mK       = 0;
        mHighRun = 0;
      end
    end
  endtask

  function automatic exp_t modelExpect();
    exp_t e;
    e.lossCnt = 8'(mLoss);
    if (!mStarted) begin
      e.rstOut = '1;
      e.ready  = 1'b0;
      e.tick   = 1'b0;
      e.state  = 2'd0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) e.rstOut[i] = (mK < i * STAGE_GAP);
      e.ready = (mK >= RUN_OFFSET);
      e.tick  = (mK > RUN_OFFSET) && (((mK - RUN_OFFSET) % TICK_DIV) == 0);
      e.state = e.ready ? 2'd2 : 2'd1;
    end
    return e;
  endfunction

  function automatic bit nextHighTicks();
    return mStarted && (mK + 1 > RUN_OFFSET) && (((mK + 1 - RUN_OFFSET) % TICK_DIV) == 0);
  endfunction

  task automatic checkOutput(input exp_t e, input string name);
    exp_t act;
    act = {rst_out, ready, tick, lock_loss_cnt, state_dbg};
    assertCount++;
    if (act !== e) begin
      failCount++;
      $display("[TB] FAIL %s @%0t: got rst_out=%b ready=%b tick=%b loss=%0d state=%0d, expected rst_out=%b ready=%b tick=%b loss=%0d state=%0d",
               name, $time, act.rstOut, act.ready, act.tick, act.lossCnt, act.state,
               e.rstOut, e.ready, e.tick, e.lossCnt, e.state);
    end
  endtask

  task automatic applyStimulus(input logic lk);
    @(negedge clock_in);
    locked_in = lk;
    modelStep(lk);
    expQ.push_back(modelExpect());
  endtask

  task automatic applyHighs(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1);
  endtask

  task automatic asyncResetMidCycle();
    exp_t resetExp;
    resetExp = '{rstOut: '1, ready: 1'b0, tick: 1'b0, lossCnt: 8'd0, state: 2'd0};
    @(negedge clock_in);
    #2 rst_in = 1'b1;
    #1 checkOutput(resetExp, "async reset immediate");
    repeat (2) @(negedge clock_in);
    checkOutput(resetExp, "async reset held");
    rst_in = 1'b0;
    modelReset();
  endtask

  // Monitor: one prediction per driven edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_in);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e, scenario);
      end
    end
  end

  initial begin
    #(40 * 100000);
    failCount++;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    exp_t resetExp;
    int guard;
    assertCount = 0;
    failCount   = 0;
    rst_in      = 1'b1;
    locked_in   = 1'b0;
    modelReset();
    resetExp = '{rstOut: '1, ready: 1'b0, tick: 1'b0, lossCnt: 8'd0, state: 2'd0};

    #5 checkOutput(resetExp, "power-on reset");
    repeat (2) @(negedge clock_in);
    rst_in = 1'b0;

    scenario = "clean start";
    applyHighs(30);

    scenario = "loss on tick edge";
    guard = 0;
    while (!nextHighTicks() && guard < 2 * TICK_DIV) begin
      applyStimulus(1'b1);
      guard++;
    end
    applyStimulus(1'b0);
    applyHighs(3);

    scenario = "unstable lock";
    applyStimulus(1'b0);
    applyHighs(7);
    applyStimulus(1'b0);
    applyHighs(20);

    scenario = "loss in release";
    applyStimulus(1'b0);
    applyHighs(9);
    applyStimulus(1'b0);
    applyHighs(24);

    scenario = "saturation";
    for (int c = 0; c < 300; c++) begin
      applyHighs(STABLE_CYCLES + RUN_OFFSET);
      applyStimulus(1'b0);
    end
    applyHighs(STABLE_CYCLES + RUN_OFFSET + 2);
    applyStimulus(1'b0);

    scenario = "async reset mid-run";
    asyncResetMidCycle();
    applyHighs(20);

    scenario = "random lock";
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0);
    end

    repeat (2) @(negedge clock_in);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
